// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: four requesters share a bank of JK bits.
// Requests are granted round-robin. Each granted {j,k} command is latched,
// applied to one bank bit, and acknowledged with a one-cycle pulse.
module jk_bank_arbiter #(
  parameter int BANK_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [7:0]           cmd,
  input  logic [4*IDX_W-1:0]   idx,
  output logic [3:0]           ack,
  output logic [BANK_W-1:0]    q,
  output logic                 busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [1:0]         ptr_r;
  logic [1:0]         win_r;
  logic [1:0]         jk_r;
  logic [IDX_W-1:0]   idx_r;
  logic [BANK_W-1:0]  q_r;
  logic [3:0]         ack_r;

  logic               launch_s;
  logic               finish_s;
  logic [1:0]         grant_s;
  logic               grant_found_s;
  logic [1:0]         cand_s;
  logic [BANK_W-1:0]  q_nxt_s;

  // Next value of one JK bit for a given {j,k} command.
  function automatic logic jk_next(input logic cur, input logic [1:0] jk);
    logic res;
    case (jk)
      2'b00:   res = cur;
      2'b01:   res = 1'b0;
      2'b10:   res = 1'b1;
      2'b11:   res = ~cur;
      default: res = cur;
    endcase
    return res;
  endfunction

  // State register; reset forces IDLE and abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE waits for any request, APPLY lasts exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s = APPLY;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      APPLY: begin
        state_nxt_s = IDLE;
        finish_s    = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Round-robin search starting at ptr_r; the first active request wins.
  always_comb begin
    grant_s       = 2'd0;
    grant_found_s = 1'b0;
    cand_s        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand_s = ptr_r + 2'(i);
      if (!grant_found_s && req[cand_s]) begin
        grant_found_s = 1'b1;
        grant_s       = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Bank update: only the latched bit changes; an index past the bank matches nothing.
  always_comb begin
    q_nxt_s = q_r;
    for (int b = 0; b < BANK_W; b++) begin
      if (int'(idx_r) == b) begin
        q_nxt_s[b] = jk_next(q_r[b], jk_r);
      end else begin
        q_nxt_s[b] = q_r[b];
      end
    end
  end

  // Datapath: latch the winner at grant, apply and acknowledge on leaving APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 2'd0;
      win_r <= 2'd0;
      jk_r  <= 2'b00;
      idx_r <= '0;
      q_r   <= '0;
      ack_r <= 4'b0000;
    end else begin
      ack_r <= 4'b0000;
      if (launch_s) begin
        win_r <= grant_s;
        jk_r  <= cmd[2*grant_s +: 2];
        idx_r <= idx[IDX_W*grant_s +: IDX_W];
      end else if (finish_s) begin
        q_r   <= q_nxt_s;
        ack_r <= 4'b0001 << win_r;
        ptr_r <= win_r + 2'd1;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign q    = q_r;
  assign ack  = ack_r;
  assign busy = (state_r == APPLY);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter.
module tb_jk_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [11:0] idx;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;

  int checks;
  int failures;

  jk_bank_arbiter #(.BANK_W(8), .IDX_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .idx  (idx),
    .ack  (ack),
    .q    (q),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic [1:0] jk, input logic [2:0] b);
    req[r]         = 1'b1;
    cmd[2*r +: 2]  = jk;
    idx[3*r +: 3]  = b;
  endtask

  // One full single-requester transaction with expected bank value.
  task automatic do_cmd(input string tag, input int r, input logic [1:0] jk,
                        input logic [2:0] b, input logic [7:0] exp_q);
    drive(r, jk, b);
    tick();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ack0"}, 32'(ack), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << r));
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    req[r] = 1'b0;
    tick();
    chk({tag, "_ackoff"}, 32'(ack), 32'd0);
    chk({tag, "_busyoff"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    req = 4'hF;
    cmd = 8'hFF;
    idx = 12'h000;

    // Reset held two cycles with every request active.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    req = 4'h0;
    cmd = 8'h00;
    tick();
    chk("post_rst_q", 32'(q), 32'h00);
    chk("post_rst_ack", 32'(ack), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single set of bit 3 by requester 0.
    do_cmd("set0", 0, 2'b10, 3'd3, 8'h08);

    // Toggle, toggle, clear, set, hold by requester 1.
    do_cmd("tog1", 1, 2'b11, 3'd3, 8'h00);
    do_cmd("tog2", 1, 2'b11, 3'd3, 8'h08);
    do_cmd("clr", 1, 2'b01, 3'd3, 8'h00);
    do_cmd("hold0", 1, 2'b00, 3'd3, 8'h00);
    do_cmd("set3", 1, 2'b10, 3'd3, 8'h08);
    do_cmd("hold1", 1, 2'b00, 3'd3, 8'h08);
    do_cmd("set7", 1, 2'b10, 3'd7, 8'h88);

    // Fairness from reset: all four request at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fair_rst_q", 32'(q), 32'h00);
    for (int r = 0; r < 4; r++) drive(r, 2'b10, 3'(r));
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("fair_busy", 32'(busy), 32'd1);
      chk("fair_ack0", 32'(ack), 32'd0);
      tick();
      chk("fair_ack", 32'(ack), 32'(4'b0001 << r));
      chk("fair_q", 32'(q), 32'((8'h01 << (r + 1)) - 8'h01));
      req[r] = 1'b0;
    end
    chk("fair_final_q", 32'(q), 32'h0F);
    tick();
    chk("fair_idle", 32'(busy), 32'd0);

    // Serve requester 2 alone so the pointer moves to 3.
    do_cmd("ptr3", 2, 2'b00, 3'd0, 8'h0F);

    // Wrap: requesters 3 and 0 together, 3 must go first.
    drive(3, 2'b10, 3'd4);
    drive(0, 2'b10, 3'd5);
    tick();
    tick();
    chk("wrap_ack3", 32'(ack), 32'h8);
    chk("wrap_q3", 32'(q), 32'h1F);
    req[3] = 1'b0;
    tick();
    chk("wrap_busy", 32'(busy), 32'd1);
    tick();
    chk("wrap_ack0", 32'(ack), 32'h1);
    chk("wrap_q0", 32'(q), 32'h3F);
    req[0] = 1'b0;
    tick();

    // Reset while a command is in APPLY; the held request is re-arbitrated.
    drive(1, 2'b10, 3'd6);
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_ack", 32'(ack), 32'h0);
    chk("mid_q", 32'(q), 32'h00);
    chk("mid_busy0", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_rearb_busy", 32'(busy), 32'd1);
    chk("mid_rearb_ack0", 32'(ack), 32'h0);
    tick();
    chk("mid_rearb_ack", 32'(ack), 32'h2);
    chk("mid_rearb_q", 32'(q), 32'h40);
    req[1] = 1'b0;
    tick();
    chk("mid_end_ack", 32'(ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
